dmem_arbiter: RTL and testbench

- Shares the single-port synchronous D-MEM between two requesters: the pipeline MEM stage (CPU) and a DMA/loader engine.
- CPU has default priority; a starvation counter and a DMA burst lock bound DMA latency.
- Produces the pipeline stall when the CPU loses arbitration.
- Sits between the MEM-stage latch outputs and the dmem array.

---
 rtl/dmem_arbiter_pkg.sv | 23 ++
 rtl/dmem_arb_starve_ctr.sv | 37 +++
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and defaults for the D-MEM arbiter (CPU MEM stage vs DMA/loader).
package dmem_arbiter_pkg;

    localparam int unsigned DMEMADDRBITS_DEF = 16;
    localparam int unsigned DMEMWORDBITS_DEF = 2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Width of a counter that must hold 0..max_val (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating DMA wait counter: counts DMA-waiting cycles, clears on a DMA grant.
module dmem_arb_starve_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned CW    = cnt_width(LIMIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clr) begin
            wait_cnt_d = '0;
        end else if (inc && (wait_cnt_q != CW'(LIMIT))) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign sat = (wait_cnt_q == CW'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port D-MEM arbiter: CPU default priority, starvation bound and DMA burst lock.
// Optional performance counters enabled with `define DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DBITS        = 32,
    parameter int unsigned DMEMADDRBITS = DMEMADDRBITS_DEF,
    parameter int unsigned DMEMWORDBITS = DMEMWORDBITS_DEF,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned BURST_MAX    = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cpu_req,
    input  logic                                 cpu_we,
    input  logic [DBITS-1:0]                     cpu_addr,
    input  logic [DBITS-1:0]                     cpu_wdata,
    output logic                                 cpu_gnt,
    output logic                                 cpu_stall,
    output logic                                 cpu_rvalid,
    output logic [DBITS-1:0]                     cpu_rdata,
    input  logic                                 dma_req,
    input  logic                                 dma_we,
    input  logic [DBITS-1:0]                     dma_addr,
    input  logic [DBITS-1:0]                     dma_wdata,
    input  logic                                 dma_lock,
    output logic                                 dma_gnt,
    output logic                                 dma_rvalid,
    output logic [DBITS-1:0]                     dma_rdata,
    output logic                                 mem_en,
    output logic                                 mem_we,
    output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr,
    output logic [DBITS-1:0]                     mem_wdata,
    input  logic [DBITS-1:0]                     mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]                          perf_cpu_stall,
    output logic [31:0]                          perf_dma_xfer
`endif
);

    localparam int unsigned BW = cnt_width(BURST_MAX);

    arb_state_e    state_q,     state_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [BW-1:0] burst_inc;
    logic          cpu_first_q, cpu_first_d;
    owner_e        rd_owner_q,  rd_owner_d;
    logic          wait_sat;
    logic          unused_addr_bits;

    dmem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (dma_req && !dma_gnt),
        .clr   (dma_gnt),
        .sat   (wait_sat)
    );

    // Grant selection; nothing is granted while reset is asserted.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            if (state_q == ST_BURST) begin
                dma_gnt = dma_req;
            end else if (cpu_req && dma_req) begin
                if (wait_sat && !cpu_first_q) dma_gnt = 1'b1;
                else                          cpu_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req;
            end
        end
    end

    assign burst_inc = burst_cnt_q + BW'(1);

    // Burst FSM, post-burst CPU preference and read-owner tag.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        cpu_first_d = cpu_first_q;
        rd_owner_d  = OWN_NONE;
        if (cpu_gnt && !cpu_we)      rd_owner_d = OWN_CPU;
        else if (dma_gnt && !dma_we) rd_owner_d = OWN_DMA;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && dma_req) cpu_first_d = 1'b0;
                if (dma_gnt && dma_lock) begin
                    state_d     = ST_BURST;
                    burst_cnt_d = BW'(1);
                end
            end
            ST_BURST: begin
                if (dma_gnt) burst_cnt_d = burst_inc;
                if (dma_gnt && (burst_inc == BW'(BURST_MAX))) begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = '0;
                    cpu_first_d = 1'b1;
                end else if (!dma_lock) begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= '0;
            cpu_first_q <= 1'b0;
            rd_owner_q  <= OWN_NONE;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            cpu_first_q <= cpu_first_d;
            rd_owner_q  <= rd_owner_d;
        end
    end

    assign cpu_stall  = cpu_req && !cpu_gnt;
    assign mem_en     = cpu_gnt || dma_gnt;
    assign mem_we     = (cpu_gnt && cpu_we) || (dma_gnt && dma_we);
    assign mem_addr   = dma_gnt ? dma_addr[DMEMADDRBITS-1:DMEMWORDBITS]
                                : cpu_addr[DMEMADDRBITS-1:DMEMWORDBITS];
    assign mem_wdata  = dma_gnt ? dma_wdata : cpu_wdata;

    // A response whose return cycle overlaps reset is dropped.
    assign cpu_rvalid = (rd_owner_q == OWN_CPU) && !reset;
    assign dma_rvalid = (rd_owner_q == OWN_DMA) && !reset;
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;

    assign unused_addr_bits = ^{cpu_addr[DBITS-1:DMEMADDRBITS], cpu_addr[DMEMWORDBITS-1:0],
                                dma_addr[DBITS-1:DMEMADDRBITS], dma_addr[DMEMWORDBITS-1:0]};

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_cpu_stall_q, perf_cpu_stall_d;
    logic [31:0] perf_dma_xfer_q,  perf_dma_xfer_d;

    always_comb begin
        perf_cpu_stall_d = perf_cpu_stall_q + 32'(cpu_stall);
        perf_dma_xfer_d  = perf_dma_xfer_q  + 32'(dma_gnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cpu_stall_q <= '0;
            perf_dma_xfer_q  <= '0;
        end else begin
            perf_cpu_stall_q <= perf_cpu_stall_d;
            perf_dma_xfer_q  <= perf_dma_xfer_d;
        end
    end

    assign perf_cpu_stall = perf_cpu_stall_q;
    assign perf_dma_xfer  = perf_dma_xfer_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic vs a rule model.
module tb_dmem_arbiter;

    localparam int unsigned STARVE = 4;
    localparam int unsigned BMAX   = 8;
    localparam int unsigned NW     = 16384;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_cpu_stall, perf_dma_xfer;
`endif

    logic [31:0] dmem   [0:NW-1];
    logic [31:0] shadow [0:NW-1];
    int errors = 0;
    int checks = 0;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_cpu_stall(perf_cpu_stall), .perf_dma_xfer(perf_dma_xfer)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dmem[mem_addr] = mem_wdata;
            else        mem_rdata <= dmem[mem_addr];
        end
    end

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_lock = 0;
    endtask

    task automatic do_reset();
        reset = 1; idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; dma_req = 1; dma_we = 1; dma_addr = 32'h20;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rst_cpu_gnt got=%b exp=0", cpu_gnt); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL rst_dma_gnt got=%b exp=0", dma_gnt); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem got=%b%b exp=00", mem_en, mem_we); end
        @(posedge clk); #1 reset = 0; idle_inputs();
        @(negedge clk);
        checks++; if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_en, mem_we, cpu_stall} !== 7'b0) begin
            errors++; $display("FAIL post_rst_outs got=%b exp=0000000", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_en, mem_we, cpu_stall});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_read();
        dmem[4] = 32'hDEADBEEF;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0010;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rd_cpu_gnt got=%b exp=1", cpu_gnt); end
        checks++; if (mem_addr !== 14'd4) begin errors++; $display("FAIL rd_mem_addr got=%0d exp=4", mem_addr); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_ctl got=%b%b exp=10", mem_en, mem_we); end
        @(posedge clk); #1 cpu_req = 0;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid got=%b exp=1", cpu_rvalid); end
        checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata got=%h exp=deadbeef", cpu_rdata); end
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL rd_dma_rvalid got=%b exp=0", dma_rvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        logic exp_d;
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h200;
        dma_req = 1; dma_we = 0; dma_addr = 32'h300; dma_lock = 0;
        for (int k = 1; k <= 10; k++) begin
            exp_d = (k % (STARVE + 1) == 0);
            @(negedge clk);
            checks++; if (dma_gnt !== exp_d) begin errors++; $display("FAIL cont_dma_gnt cyc=%0d got=%b exp=%b", k, dma_gnt, exp_d); end
            checks++; if (cpu_gnt !== !exp_d) begin errors++; $display("FAIL cont_cpu_gnt cyc=%0d got=%b exp=%b", k, cpu_gnt, !exp_d); end
            checks++; if (cpu_stall !== exp_d) begin errors++; $display("FAIL cont_stall cyc=%0d got=%b exp=%b", k, cpu_stall, exp_d); end
            @(posedge clk); #1;
        end
`ifdef DMEM_ARB_PERF_EN
        checks++; if (perf_cpu_stall !== 32'd2) begin errors++; $display("FAIL perf_stall got=%0d exp=2", perf_cpu_stall); end
        checks++; if (perf_dma_xfer !== 32'd2) begin errors++; $display("FAIL perf_xfer got=%0d exp=2", perf_dma_xfer); end
`endif
        idle_inputs();
    endtask

    task automatic test_burst();
        int  widx;
        logic exp_d;
        do_reset();
        widx = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h800;
        for (int c = 1; c <= 20; c++) begin
            dma_req   = (widx < 10);
            dma_we    = 1;
            dma_addr  = 32'hFFFF_0000 | (32'h100 + 32'(4 * widx));
            dma_wdata = 32'hB000_0000 + 32'(widx);
            dma_lock  = (widx < 9);
            exp_d = (c >= 5 && c <= 12) || c == 17 || c == 18;
            @(negedge clk);
            checks++; if (dma_gnt !== exp_d) begin errors++; $display("FAIL burst_dma_gnt cyc=%0d got=%b exp=%b", c, dma_gnt, exp_d); end
            checks++; if (cpu_gnt !== !exp_d) begin errors++; $display("FAIL burst_cpu_gnt cyc=%0d got=%b exp=%b", c, cpu_gnt, !exp_d); end
            if (exp_d) begin
                checks++; if (mem_we !== 1'b1 || mem_addr !== 14'(32'h40 + widx) || mem_wdata !== 32'hB000_0000 + 32'(widx)) begin
                    errors++; $display("FAIL burst_wr cyc=%0d got=%b/%h/%h exp=1/%h/%h", c, mem_we, mem_addr, mem_wdata, 14'(32'h40 + widx), 32'hB000_0000 + 32'(widx));
                end
                widx++;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_raw();
        do_reset();
        dmem[16] = 32'h0;
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h12345678; dma_lock = 0;
        cpu_req = 1; cpu_we = 0;
        for (int c = 1; c <= 6; c++) begin
            cpu_addr = (c < 5) ? 32'h80 + 32'(4 * c) : 32'h40;
            @(negedge clk);
            if (c < 5) begin
                checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL raw_pre cyc=%0d got=%b exp=1", c, cpu_gnt); end
            end else if (c == 5) begin
                checks++; if (dma_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 14'd16) begin
                    errors++; $display("FAIL raw_dma_wr got=%b%b%b/%h exp=111/0010", dma_gnt, cpu_stall, mem_we, mem_addr);
                end
            end else begin
                checks++; if (cpu_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 14'd16) begin
                    errors++; $display("FAIL raw_cpu_rd got=%b%b/%h exp=10/0010", cpu_gnt, mem_we, mem_addr);
                end
            end
            @(posedge clk); #1;
            if (c == 5) dma_req = 0;
        end
        cpu_req = 0;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678) begin
            errors++; $display("FAIL raw_data got=%b/%h exp=1/12345678", cpu_rvalid, cpu_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_drop();
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rdrop_gnt got=%b exp=1", cpu_gnt); end
        @(posedge clk); #1 reset = 1; cpu_req = 0;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rdrop_rvalid got=%b exp=0", cpu_rvalid); end
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        checks++; if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_en, mem_we} !== 6'b0) begin
            errors++; $display("FAIL rdrop_after got=%b exp=000000", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_en, mem_we});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int   m_wait, m_bcnt, rv_owner;
        bit   m_burst, m_cpufirst, cpu_pend, dma_pend, dma_lock_t, exp_c, exp_d;
        logic [31:0] rv_data;
        do_reset();
        for (int i = 0; i < NW; i++) shadow[i] = dmem[i];
        m_wait = 0; m_bcnt = 0; m_burst = 0; m_cpufirst = 0; rv_owner = 0; rv_data = 0;
        cpu_pend = 0; dma_pend = 0; dma_lock_t = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!cpu_pend && ($urandom % 10) < 6) begin
                cpu_pend = 1; cpu_we = 1'($urandom % 2); cpu_wdata = $urandom;
                cpu_addr = ($urandom & 32'hFFFF_0000) | (($urandom % 32) << 2) | ($urandom % 4);
            end
            if (!dma_pend && ($urandom % 10) < 5) begin
                dma_pend = 1; dma_we = 1'($urandom % 2); dma_wdata = $urandom; dma_lock_t = 1'($urandom % 2);
                dma_addr = ($urandom & 32'hFFFF_0000) | (($urandom % 32) << 2) | ($urandom % 4);
            end
            cpu_req = cpu_pend; dma_req = dma_pend; dma_lock = dma_pend && dma_lock_t;
            exp_d = m_burst ? dma_req : (dma_req && (!cpu_req || (m_wait == STARVE && !m_cpufirst)));
            exp_c = !m_burst && cpu_req && !exp_d;
            @(negedge clk);
            checks++; if (cpu_gnt !== exp_c || dma_gnt !== exp_d) begin
                errors++; $display("FAIL rnd_gnt cyc=%0d got=%b%b exp=%b%b", cyc, cpu_gnt, dma_gnt, exp_c, exp_d);
            end
            checks++; if (cpu_stall !== (cpu_req && !exp_c)) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, cpu_stall, cpu_req && !exp_c); end
            checks++; if (cpu_rvalid !== (rv_owner == 1) || dma_rvalid !== (rv_owner == 2)) begin
                errors++; $display("FAIL rnd_rvalid cyc=%0d got=%b%b exp_owner=%0d", cyc, cpu_rvalid, dma_rvalid, rv_owner);
            end
            if (rv_owner != 0) begin
                checks++; if ((rv_owner == 1 ? cpu_rdata : dma_rdata) !== rv_data) begin
                    errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, (rv_owner == 1 ? cpu_rdata : dma_rdata), rv_data);
                end
            end
            if (exp_c || exp_d) begin
                checks++; if (mem_en !== 1'b1 || mem_addr !== (exp_d ? dma_addr[15:2] : cpu_addr[15:2]) || mem_we !== (exp_d ? dma_we : cpu_we)) begin
                    errors++; $display("FAIL rnd_mem cyc=%0d got=%b%b/%h", cyc, mem_en, mem_we, mem_addr);
                end
            end
            // Advance the reference view of memory, responses and arbitration history.
            rv_owner = 0;
            if (exp_c) begin
                if (cpu_we) shadow[cpu_addr[15:2]] = cpu_wdata;
                else begin rv_owner = 1; rv_data = shadow[cpu_addr[15:2]]; end
                cpu_pend = 0;
            end
            if (exp_d) begin
                if (dma_we) shadow[dma_addr[15:2]] = dma_wdata;
                else begin rv_owner = 2; rv_data = shadow[dma_addr[15:2]]; end
                dma_pend = 0;
            end
            if (!m_burst) begin
                if (cpu_req && dma_req) m_cpufirst = 0;
                if (exp_d && dma_lock) begin m_burst = 1; m_bcnt = 1; end
            end else begin
                if (exp_d) m_bcnt++;
                if (exp_d && m_bcnt == BMAX) begin m_burst = 0; m_cpufirst = 1; end
                else if (!dma_lock) m_burst = 0;
            end
            if (exp_d) m_wait = 0;
            else if (dma_req && m_wait < STARVE) m_wait++;
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < NW; i++) dmem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
        mem_rdata = 32'h0;
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_contention();
        test_burst();
        test_raw();
        test_reset_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
